// File: rtl/i2c_pkg.sv
// Shared types for the I2C target register file.
// FSM state encoding, filtered-line bundle and default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } line_t;

  localparam logic [6:0] DEVICE_ADDR_DEFAULT = 7'h3C;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Avalon-MM register port of the I2C target register file.
// The CPU side is the master, the register file is the slave.
interface i2c_target_regfile_if #(
  parameter int AW = 4
);

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser plus debounce for one I2C line.
// Emits the accepted level and one-clk rise/fall pulses.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  pin,
  output line_t sig
);

  logic                  s1;
  logic                  s2;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] win;
  logic                  level_nx;

  assign win = {hist, s2};

  always_comb begin
    level_nx = sig.level;
    if (&win) begin
      level_nx = 1'b1;
    end else if (~|win) begin
      level_nx = 1'b0;
    end
  end

  // Idle bus is high, so reset to high to avoid a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= '1;
      sig  <= '{level: 1'b1, rise: 1'b0, fall: 1'b0};
    end else begin
      s1        <= pin;
      s2        <= s1;
      hist      <= win[FILTER_LEN-2:0];
      sig.level <= level_nx;
      sig.rise  <= level_nx & ~sig.level;
      sig.fall  <= ~level_nx & sig.level;
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing NUM_REGS byte registers, shared with an
// Avalon-MM slave port for the CPU.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = DEVICE_ADDR_DEFAULT,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  i2c_target_regfile_if.slave bus,
  output logic i2c_wr_irq,
  output logic busy
);

  localparam int AW = $clog2(NUM_REGS);

  line_t         scl;
  line_t         sda;
  i2c_state_e    state;
  i2c_state_e    state_nx;
  logic [7:0]    regs [NUM_REGS];
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rd_byte;
  logic [7:0]    rd_src;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_plus;
  logic          start;
  logic          stop;
  logic          byte_done;
  logic          addr_hit;
  logic          cnt_en;
  logic          shift_en;
  logic          oe_nx;
  logic          busy_nx;
  logic          wr_en;
  logic          rd_load;
  logic          ptr_load;
  logic          ptr_inc;
  logic          av_we;
  logic          unused_wdata;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (scl_in),
    .sig     (scl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (sda_in),
    .sig     (sda)
  );

  assign start     = sda.fall & scl.level;
  assign stop      = sda.rise & scl.level;
  assign byte_done = (bit_cnt == 4'd8);
  assign addr_hit  = (shreg[7:1] == DEVICE_ADDR) &&
                     (shreg[7:1] != 7'h00);
  assign ptr_plus  = ptr + 1'b1;
  assign av_we     = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:8];

  assign cnt_en = scl.rise & ~byte_done &
                  (state inside {ADDR, PTR, WR_DATA, RD_DATA});
  assign shift_en = scl.rise &
                    (state inside {ADDR, PTR, WR_DATA, RD_ACK});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = ADDR;
    end else if (scl.fall) begin
      unique case (state)
        ADDR:
          if (byte_done) state_nx = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_nx = shreg[0] ? RD_DATA : PTR;
        PTR:      if (byte_done) state_nx = PTR_ACK;
        PTR_ACK:  state_nx = WR_DATA;
        WR_DATA:  if (byte_done) state_nx = WR_ACK;
        WR_ACK:   state_nx = WR_DATA;
        RD_DATA:  if (byte_done) state_nx = RD_ACK;
        RD_ACK:   state_nx = shreg[0] ? IGNORE : RD_DATA;
        default:  state_nx = state;
      endcase
    end
  end

  // Drive changes only on the filtered SCL fall; shreg[0] holds R/W or master ACK.
  always_comb begin
    oe_nx    = sda_oe;
    busy_nx  = busy;
    wr_en    = 1'b0;
    rd_load  = 1'b0;
    rd_src   = regs[ptr];
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    if (stop) begin
      oe_nx   = 1'b0;
      busy_nx = 1'b0;
    end else if (start) begin
      oe_nx = 1'b0;
    end else if (scl.fall) begin
      unique case (state)
        ADDR:
          if (byte_done && addr_hit) begin
            oe_nx   = 1'b1;
            busy_nx = 1'b1;
          end
        ADDR_ACK: begin
          oe_nx   = 1'b0;
          rd_load = shreg[0];
        end
        PTR:
          if (byte_done) begin
            oe_nx    = 1'b1;
            ptr_load = 1'b1;
          end
        PTR_ACK: oe_nx = 1'b0;
        WR_DATA: if (byte_done) oe_nx = 1'b1;
        WR_ACK: begin
          oe_nx   = 1'b0;
          wr_en   = 1'b1;
          ptr_inc = 1'b1;
        end
        RD_DATA:
          oe_nx = byte_done ? 1'b0 :
                  ~rd_byte[3'd7 - bit_cnt[2:0]];
        RD_ACK: begin
          oe_nx = 1'b0;
          if (!shreg[0]) begin
            ptr_inc = 1'b1;
            rd_load = 1'b1;
            rd_src  = regs[ptr_plus];
          end
        end
        default: oe_nx = sda_oe;
      endcase
      if (rd_load) oe_nx = ~rd_src[7];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      rd_byte    <= '0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      i2c_wr_irq <= 1'b0;
    end else begin
      sda_oe     <= oe_nx;
      busy       <= busy_nx;
      i2c_wr_irq <= wr_en;
      if (start || state_nx != state) begin
        bit_cnt <= '0;
      end else if (cnt_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) shreg <= {shreg[6:0], sda.level};
      if (rd_load) rd_byte <= rd_src;
      if (ptr_load) begin
        ptr <= shreg[AW-1:0];
      end else if (ptr_inc) begin
        ptr <= ptr_plus;
      end
    end
  end

  // I2C write takes priority over a CPU write to the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.readdata <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && int'(ptr) == i) begin
          regs[i] <= shreg;
        end else if (av_we && int'(bus.address) == i) begin
          regs[i] <= bus.writedata[7:0];
        end
      end
      bus.readdata <= {24'b0, regs[bus.address]};
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master
// plus Avalon accesses, with hand-computed expectations.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic m_scl;
  logic m_sda;
  logic bypass;
  logic sda_line;
  logic sda_oe;
  logic irq;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   irq_cnt = 0;
  int   oe_cnt = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  i2c_target_regfile_if #(.AW(4)) bus ();

  // Open-drain bus; bypass lets the master see its own level only.
  assign sda_line = m_sda & ~(sda_oe & ~bypass);

  i2c_target_regfile dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_in     (m_scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .bus        (bus),
    .i2c_wr_irq (irq),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input logic glitch,
                           output logic r);
    m_sda = b;
    if (glitch) begin
      wait_clk(4);
      m_scl = 1'b1;
      wait_clk(1);
      m_scl = 1'b0;
      wait_clk(5);
    end else begin
      wait_clk(10);
    end
    m_scl = 1'b1;
    wait_clk(10);
    r = sda_line;
    wait_clk(10);
    m_scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(20);
    m_sda = 1'b0;
    wait_clk(20);
    m_scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(20);
    m_sda = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit,
                           output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], i == gbit, r);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    clock_bit(mack, 1'b0, r);
  endtask

  task automatic av_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = {24'hABCDEF, d};
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    bypass = 1'b0;
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    wait_clk(3);
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++; $display("FAIL rst_oe: got %b want 0", sda_oe);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL rst_irq: got %b want 0", irq);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h want 0", bus.readdata);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL rst_state: got %0d want IDLE", dut.state);
    end
    reset_n = 1'b1;
    wait_clk(5);
    av_read(4'd9, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_reg9: got %h want 0", d);
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    logic [31:0] d;
    int irq0;
    irq0 = irq_cnt;
    i2c_start();
    send_byte(8'h78, -1, a0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy: got %b want 1", busy);
    end
    send_byte(8'h02, -1, a1);
    send_byte(8'hA5, -1, a2);
    send_byte(8'h5A, -1, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b0000) begin
      errors++; $display("FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3});
    end
    checks++;
    if (irq_cnt - irq0 !== 2) begin
      errors++; $display("FAIL wr_irq: got %0d want 2", irq_cnt - irq0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_busy_stop: got %b want 0", busy);
    end
    av_read(4'd2, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      errors++; $display("FAIL wr_reg2: got %h want 000000a5", d);
    end
    av_read(4'd3, d);
    checks++;
    if (d !== 32'h0000_005A) begin
      errors++; $display("FAIL wr_reg3: got %h want 0000005a", d);
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    av_write(4'd5, 8'h3C);
    av_write(4'd6, 8'hC3);
    i2c_start();
    send_byte(8'h78, -1, a0);
    send_byte(8'h05, -1, a1);
    i2c_start();
    send_byte(8'h79, -1, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      errors++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2});
    end
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    checks++;
    if (b0 !== 8'h3C) begin
      errors++; $display("FAIL rd_byte0: got %h want 3c", b0);
    end
    checks++;
    if (b1 !== 8'hC3) begin
      errors++; $display("FAIL rd_byte1: got %h want c3", b1);
    end
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++; $display("FAIL rd_release: got %b want 0", sda_oe);
    end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    logic [31:0] d;
    int oe0, busy0;
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    send_byte(8'h7A, -1, a0);
    send_byte(8'h01, -1, a1);
    i2c_stop();
    checks++;
    if ({a0, a1} !== 2'b11) begin
      errors++; $display("FAIL mm_nack: got %b want 11", {a0, a1});
    end
    checks++;
    if (oe_cnt - oe0 !== 0) begin
      errors++; $display("FAIL mm_oe: got %0d want 0", oe_cnt - oe0);
    end
    checks++;
    if (busy_cnt - busy0 !== 0) begin
      errors++; $display("FAIL mm_busy: got %0d want 0", busy_cnt - busy0);
    end
    av_read(4'd1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL mm_reg1: got %h want 0", d);
    end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    logic [31:0] d;
    i2c_start();
    send_byte(8'h78, -1, a0);
    send_byte(8'h0F, -1, a1);
    send_byte(8'h11, -1, a2);
    send_byte(8'h22, -1, a3);
    i2c_stop();
    av_read(4'd15, d);
    checks++;
    if (d !== 32'h11) begin
      errors++; $display("FAIL wrap_reg15: got %h want 11", d);
    end
    av_read(4'd0, d);
    checks++;
    if (d !== 32'h22) begin
      errors++; $display("FAIL wrap_reg0: got %h want 22", d);
    end
  endtask

  task automatic test_collision();
    logic a0, a1, r;
    logic [7:0] v;
    logic [31:0] d;
    v = 8'h01;
    i2c_start();
    send_byte(8'h78, -1, a0);
    send_byte(8'h04, -1, a1);
    for (int i = 7; i >= 0; i--) clock_bit(v[i], 1'b0, r);
    m_sda = 1'b1;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(10);
    r = sda_line;
    wait_clk(10);
    m_scl = 1'b0;
    // I2C write lands 6 clks after the raw SCL fall
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.address = 4'd4;
    bus.writedata = 32'h0000_00FF;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL col_irq: got %b want 1", irq);
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    wait_clk(9);
    i2c_stop();
    checks++;
    if (r !== 1'b0) begin
      errors++; $display("FAIL col_ack: got %b want 0", r);
    end
    av_read(4'd4, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL col_reg4: got %h want 01", d);
    end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, r;
    av_write(4'd7, 8'h00);
    i2c_start();
    send_byte(8'h78, -1, a0);
    send_byte(8'h07, -1, a1);
    i2c_start();
    send_byte(8'h79, -1, a2);
    clock_bit(1'b1, 1'b0, r);
    clock_bit(1'b1, 1'b0, r);
    bypass = 1'b1;
    m_sda = 1'b0;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(10);
    checks++;
    if (sda_oe !== 1'b1) begin
      errors++; $display("FAIL ab_drive: got %b want 1", sda_oe);
    end
    m_sda = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++; $display("FAIL ab_release: got %b want 0", sda_oe);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL ab_state: got %0d want IDLE", dut.state);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ab_busy: got %b want 0", busy);
    end
    wait_clk(10);
    bypass = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    logic [31:0] d;
    i2c_start();
    send_byte(8'h78, -1, a0);
    send_byte(8'h08, -1, a1);
    send_byte(8'h96, 4, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      errors++; $display("FAIL gl_acks: got %b want 000", {a0, a1, a2});
    end
    av_read(4'd8, d);
    checks++;
    if (d !== 32'h96) begin
      errors++; $display("FAIL gl_reg8: got %h want 96", d);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_collision();
    test_abort();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
